// File: rtl/load_unit_if.sv
// Receive-side loader bus: global status and memory size in, UART byte strobe in,
// sample-memory write port and end/error flags out.
interface load_unit_if #(
  parameter int unsigned DATA_SIZE        = 16,
  parameter int unsigned UART_DATA_SIZE   = 8,
  parameter int unsigned ADDR_SIZE        = 13,
  parameter int unsigned IAGC_STATUS_SIZE = 4
);

  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status;
  logic [ADDR_SIZE-1:0]        i_memory_size;
  logic [UART_DATA_SIZE-1:0]   i_rx_data;
  logic                        i_rx_valid;
  logic [ADDR_SIZE-1:0]        o_waddr;
  logic [DATA_SIZE-1:0]        o_wdata;
  logic                        o_wen;
  logic                        o_end;
  logic                        o_error;

  // Driver side: FSM status, UART receiver and memory sink.
  modport master (
    output i_iagc_status, i_memory_size, i_rx_data, i_rx_valid,
    input  o_waddr, o_wdata, o_wen, o_end, o_error
  );

  // Loader side.
  modport slave (
    input  i_iagc_status, i_memory_size, i_rx_data, i_rx_valid,
    output o_waddr, o_wdata, o_wen, o_end, o_error
  );

endinterface

// File: rtl/load_unit.sv
// UART-to-memory loader: pairs received bytes (low first) into samples, writes them
// to consecutive addresses from 0, flags completion and inter-byte timeouts.
module load_unit #(
  parameter int unsigned DATA_SIZE        = 16,
  parameter int unsigned UART_DATA_SIZE   = 8,
  parameter int unsigned ADDR_SIZE        = 13,
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0] LOAD_STATUS = IAGC_STATUS_SIZE'(6),
  parameter int unsigned TIMEOUT_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_SIZE     = 17
) (
  input logic        i_clock,
  input logic        i_reset,
  load_unit_if.slave bus
);

  localparam logic [ADDR_SIZE-1:0]    ADDR_ONE   = ADDR_SIZE'(1);
  localparam logic [TIMEOUT_SIZE-1:0] TIMER_ONE  = TIMEOUT_SIZE'(1);
  localparam logic [TIMEOUT_SIZE-1:0] TIMER_LAST = TIMEOUT_SIZE'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic [TIMEOUT_SIZE-1:0]   timer_q, timer_d;
  logic [UART_DATA_SIZE-1:0] low_q, low_d;
  logic [ADDR_SIZE-1:0]      waddr_q, waddr_d;
  logic [DATA_SIZE-1:0]      wdata_q, wdata_d;
  logic                      wen_q, wen_d;
  logic                      end_q, end_d;
  logic                      error_q, error_d;

  logic load_c;
  logic last_c;
  logic expired_c;

  assign load_c    = (bus.i_iagc_status == LOAD_STATUS);
  assign last_c    = (addr_q == (bus.i_memory_size - ADDR_ONE));
  assign expired_c = (timer_q == TIMER_LAST);

  // Next-state and registered-output logic; wen/end/error are re-asserted every cycle they hold.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    low_d   = low_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    end_d   = 1'b0;
    error_d = 1'b0;

    if (state_q != ST_IDLE && !load_c) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_d  = '0;
          timer_d = '0;
          if (load_c) begin
            if (bus.i_memory_size == '0) begin
              state_d = ST_DONE;
              end_d   = 1'b1;
            end else begin
              state_d = ST_LOW;
            end
          end
        end

        ST_LOW: begin
          if (bus.i_rx_valid) begin
            low_d   = bus.i_rx_data;
            timer_d = '0;
            state_d = ST_HIGH;
          end else if (addr_q != '0) begin
            // Waiting for the very first byte of a load never times out.
            if (expired_c) begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end else begin
              timer_d = timer_q + TIMER_ONE;
            end
          end
        end

        ST_HIGH: begin
          if (bus.i_rx_valid) begin
            waddr_d = addr_q;
            wdata_d = {bus.i_rx_data, low_q};
            wen_d   = 1'b1;
            timer_d = '0;
            if (last_c) begin
              state_d = ST_DONE;
              end_d   = 1'b1;
            end else begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = ST_LOW;
            end
          end else if (expired_c) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_DONE:  end_d   = 1'b1;

        ST_ERROR: error_d = 1'b1;

        default: begin
          state_d = ST_IDLE;
          addr_d  = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      timer_q <= '0;
      low_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      end_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
      low_q   <= low_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      end_q   <= end_d;
      error_q <= error_d;
    end
  end

  assign bus.o_waddr = waddr_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_wen   = wen_q;
  assign bus.o_end   = end_q;
  assign bus.o_error = error_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit with a 50-cycle inter-byte timeout.
module tb_load_unit;

  localparam int unsigned TO = 50;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;
  int   wen_count;
  int   w0;

  load_unit_if #(.DATA_SIZE(16), .UART_DATA_SIZE(8), .ADDR_SIZE(13), .IAGC_STATUS_SIZE(4)) bus ();

  load_unit #(
    .DATA_SIZE(16), .UART_DATA_SIZE(8), .ADDR_SIZE(13), .IAGC_STATUS_SIZE(4),
    .LOAD_STATUS(4'd6), .TIMEOUT_CYCLES(TO), .TIMEOUT_SIZE(17)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; tally every write strobe seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.o_wen === 1'b1) wen_count++;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    wen_count = 0;
    rst_n     = 1'b0;
    bus.i_iagc_status = 4'd0;
    bus.i_memory_size = 13'd0;
    bus.i_rx_data     = 8'd0;
    bus.i_rx_valid    = 1'b0;
    tick();
    tick();
    chk("rst_waddr", 32'(bus.o_waddr), 32'h0);
    chk("rst_wdata", 32'(bus.o_wdata), 32'h0);
    chk("rst_wen",   32'(bus.o_wen),   32'h0);
    chk("rst_end",   32'(bus.o_end),   32'h0);
    chk("rst_error", 32'(bus.o_error), 32'h0);
    rst_n = 1'b1;

    // Normal load of 4 samples, then a stray byte
    bus.i_memory_size = 13'd4;
    bus.i_iagc_status = 4'd6;
    tick();
    send(8'h34); send(8'h12);
    chk("n_wen0",   32'(bus.o_wen),   32'h1);
    chk("n_addr0",  32'(bus.o_waddr), 32'h0);
    chk("n_data0",  32'(bus.o_wdata), 32'h1234);
    chk("n_end0",   32'(bus.o_end),   32'h0);
    send(8'h78);
    chk("n_gap_wen",  32'(bus.o_wen),   32'h0);
    chk("n_gap_addr", 32'(bus.o_waddr), 32'h0);
    chk("n_gap_data", 32'(bus.o_wdata), 32'h1234);
    send(8'h56);
    chk("n_addr1",  32'(bus.o_waddr), 32'h1);
    chk("n_data1",  32'(bus.o_wdata), 32'h5678);
    send(8'hBC); send(8'h9A);
    chk("n_addr2",  32'(bus.o_waddr), 32'h2);
    chk("n_data2",  32'(bus.o_wdata), 32'h9ABC);
    send(8'hF0); send(8'hDE);
    chk("n_wen3",   32'(bus.o_wen),   32'h1);
    chk("n_addr3",  32'(bus.o_waddr), 32'h3);
    chk("n_data3",  32'(bus.o_wdata), 32'hDEF0);
    chk("n_end3",   32'(bus.o_end),   32'h1);
    send(8'h55);
    tick();
    chk("n_extra_wen", 32'(bus.o_wen), 32'h0);
    chk("n_end_hold",  32'(bus.o_end), 32'h1);
    chk("n_wcount",    32'(wen_count), 32'd4);

    // Timeout after a lone low byte
    bus.i_iagc_status = 4'd0;
    tick();
    chk("t_end_drop", 32'(bus.o_end), 32'h0);
    bus.i_iagc_status = 4'd6;
    tick();
    send(8'h11);
    w0 = wen_count;
    repeat (TO - 1) tick();
    chk("t_err_early", 32'(bus.o_error), 32'h0);
    tick();
    chk("t_err_rise", 32'(bus.o_error), 32'h1);
    chk("t_no_write", 32'(wen_count),   32'(w0));
    bus.i_iagc_status = 4'd0;
    tick();
    chk("t_err_clear", 32'(bus.o_error), 32'h0);

    // First-byte wait never expires; byte on the expiry cycle wins
    bus.i_memory_size = 13'd2;
    bus.i_iagc_status = 4'd6;
    tick();
    repeat (500) tick();
    chk("f_wait_err", 32'(bus.o_error), 32'h0);
    send(8'hA1);
    repeat (TO - 1) tick();
    chk("f_pre_err", 32'(bus.o_error), 32'h0);
    send(8'hB2);
    chk("f_race_err",  32'(bus.o_error), 32'h0);
    chk("f_race_wen",  32'(bus.o_wen),   32'h1);
    chk("f_race_addr", 32'(bus.o_waddr), 32'h0);
    chk("f_race_data", 32'(bus.o_wdata), 32'hB2A1);
    send(8'hC3); send(8'hD4);
    chk("f_addr1", 32'(bus.o_waddr), 32'h1);
    chk("f_data1", 32'(bus.o_wdata), 32'hD4C3);
    chk("f_end",   32'(bus.o_end),   32'h1);

    // Abort mid-frame and restart from address 0
    bus.i_iagc_status = 4'd0;
    tick();
    bus.i_memory_size = 13'd4;
    bus.i_iagc_status = 4'd6;
    tick();
    send(8'h01); send(8'h02);
    chk("a_addr0", 32'(bus.o_waddr), 32'h0);
    chk("a_data0", 32'(bus.o_wdata), 32'h0201);
    send(8'h03);
    bus.i_iagc_status = 4'd0;
    tick();
    w0 = wen_count;
    send(8'h04);
    tick();
    chk("a_no_write", 32'(wen_count), 32'(w0));
    chk("a_end",      32'(bus.o_end), 32'h0);
    bus.i_iagc_status = 4'd6;
    tick();
    send(8'h05); send(8'h06);
    chk("a_re_wen",  32'(bus.o_wen),   32'h1);
    chk("a_re_addr", 32'(bus.o_waddr), 32'h0);
    chk("a_re_data", 32'(bus.o_wdata), 32'h0605);

    // Empty load
    bus.i_iagc_status = 4'd0;
    tick();
    bus.i_memory_size = 13'd0;
    bus.i_iagc_status = 4'd6;
    w0 = wen_count;
    tick();
    chk("e_end",  32'(bus.o_end), 32'h1);
    chk("e_wen",  32'(bus.o_wen), 32'h0);
    tick();
    chk("e_end_hold", 32'(bus.o_end),   32'h1);
    chk("e_no_write", 32'(wen_count),   32'(w0));
    bus.i_iagc_status = 4'd0;
    tick();
    chk("e_end_drop", 32'(bus.o_end), 32'h0);

    // Back-to-back bytes with valid held high
    bus.i_memory_size = 13'd2;
    bus.i_iagc_status = 4'd6;
    tick();
    w0 = wen_count;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data = 8'h11; tick();
    bus.i_rx_data = 8'h22; tick();
    chk("b_addr0", 32'(bus.o_waddr), 32'h0);
    chk("b_data0", 32'(bus.o_wdata), 32'h2211);
    bus.i_rx_data = 8'h33; tick();
    chk("b_gap_wen", 32'(bus.o_wen), 32'h0);
    bus.i_rx_data = 8'h44; tick();
    bus.i_rx_valid = 1'b0;
    chk("b_addr1",  32'(bus.o_waddr),   32'h1);
    chk("b_data1",  32'(bus.o_wdata),   32'h4433);
    chk("b_end",    32'(bus.o_end),     32'h1);
    chk("b_writes", 32'(wen_count - w0), 32'd2);

    // Asynchronous reset between edges, mid-load
    bus.i_iagc_status = 4'd0;
    tick();
    bus.i_memory_size = 13'd4;
    bus.i_iagc_status = 4'd6;
    tick();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("r_pre_addr", 32'(bus.o_waddr), 32'h1);
    chk("r_pre_data", 32'(bus.o_wdata), 32'h0403);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_waddr", 32'(bus.o_waddr), 32'h0);
    chk("r_wdata", 32'(bus.o_wdata), 32'h0);
    chk("r_wen",   32'(bus.o_wen),   32'h0);
    chk("r_end",   32'(bus.o_end),   32'h0);
    chk("r_error", 32'(bus.o_error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(8'h0A); send(8'h0B);
    chk("r_post_wen",  32'(bus.o_wen),   32'h1);
    chk("r_post_addr", 32'(bus.o_waddr), 32'h0);
    chk("r_post_data", 32'(bus.o_wdata), 32'h0B0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

UART-to-memory loader: the receive-direction counterpart of the dump path. While the IAGC FSM is in the load status, it takes bytes from `uart_rx`, pairs them into 16-bit samples (low byte first) and writes them to sample memory at consecutive addresses from 0 up to `i_memory_size - 1`. It then asserts `o_end` for the FSM. An inter-byte timeout flags broken frames.

## Interface

Parameters
- `DATA_SIZE`, 16: sample width written to memory.
- `UART_DATA_SIZE`, 8: received byte width; `DATA_SIZE = 2*UART_DATA_SIZE`.
- `ADDR_SIZE`, 13: memory address width.
- `IAGC_STATUS_SIZE`, 4: status bus width.
- `LOAD_STATUS`, 4'd6: status code that enables loading.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles inside a frame (1 ms at 100 MHz).
- `TIMEOUT_SIZE`, 17: timer width; must satisfy `2^TIMEOUT_SIZE > TIMEOUT_CYCLES`.

Ports
- `i_clock`, in, 1: system clock. One clock domain only.
- `i_reset`, in, 1: reset, asynchronous, active-low.
- `i_iagc_status`, in, `IAGC_STATUS_SIZE`: global FSM status.
- `i_memory_size`, in, `ADDR_SIZE`: number of samples to load.
- `i_rx_data`, in, `UART_DATA_SIZE`: received byte, valid when `i_rx_valid` is high.
- `i_rx_valid`, in, 1: one-cycle strobe per received byte.
- `o_waddr`, out, `ADDR_SIZE`: memory write address.
- `o_wdata`, out, `DATA_SIZE`: memory write data.
- `o_wen`, out, 1: one-cycle write strobe.
- `o_end`, out, 1: load complete. Level signal.
- `o_error`, out, 1: frame timeout. Level signal.

## Operation

- **States:** IDLE, LOW, HIGH, DONE, ERROR.
- **IDLE.** Address counter = 0, timer = 0.
  - When `i_iagc_status == LOAD_STATUS`: if `i_memory_size == 0`, go to DONE; otherwise go to LOW.
- **LOW.** On `i_rx_valid`, latch `i_rx_data` as the low byte, clear the timer, go to HIGH.
- **HIGH.** On `i_rx_valid`, register the following for the next cycle:
  - `o_wdata = {i_rx_data, low}`
  - `o_waddr = addr`
  - `o_wen = 1`
  - Clear the timer.
  - If `addr == i_memory_size - 1`, go to DONE. Otherwise `addr <= addr + 1` and go to LOW.
- **DONE.** `o_end = 1`. Bytes are ignored.
- **ERROR.** `o_error = 1`. Bytes are ignored.
- **Timer.** Counts every cycle in HIGH, and in LOW when `addr != 0`. It does not run in LOW with `addr == 0`, so waiting for the first byte never times out.
  - When the timer reaches `TIMEOUT_CYCLES - 1` without `i_rx_valid`, go to ERROR.
  - If `i_rx_valid` arrives on the expiry cycle, the byte wins and no error is raised.
- **Abort.** In any non-IDLE state, `i_iagc_status != LOAD_STATUS` returns the block to IDLE on the next edge.
  - No further `o_wen` is issued.
  - `o_end` and `o_error` drop.
  - A pending low byte is discarded.
  - Re-entering load restarts at address 0.
- **Other rules.**
  - `i_memory_size` is sampled continuously. The team requires it to be stable throughout a load.
  - Address arithmetic is modulo `2^ADDR_SIZE`. The counter never exceeds `i_memory_size - 1`.

## Timing

- **Reset:** state IDLE; `o_waddr = 0`, `o_wdata = 0`, `o_wen = 0`, `o_end = 0`, `o_error = 0`; address = 0; timer = 0. Reset acts immediately and asynchronously, including mid-frame.
- **Write latency:** `o_wen` is high exactly one cycle, in the cycle after the high byte's `i_rx_valid`. `o_waddr` and `o_wdata` are valid in that same cycle.
- **Between writes:** `o_wen` is 0, and `o_waddr`/`o_wdata` hold their last values.
- **Completion:** `o_end` rises on the same edge as the final `o_wen` and stays high until the status leaves `LOAD_STATUS`.
- **Empty load:** with `i_memory_size == 0`, `o_end` rises one cycle after entering `LOAD_STATUS`.
- **Timeout:** `o_error` rises `TIMEOUT_CYCLES` cycles after the last accepted byte.
- **Throughput:** back-to-back `i_rx_valid` on consecutive cycles must be accepted with no byte loss. The block has no stall path.

## Test plan

1. **Normal load.** `TIMEOUT_CYCLES=50`, size 4, status 6. Send bytes 34,12,78,56,BC,9A,F0,DE, then 55.
   - Expect writes (0,1234), (1,5678), (2,9ABC), (3,DEF0).
   - `o_end` rises with the 4th `o_wen`.
   - The extra byte 55 causes no write.
2. **Timeout.** Size 4; send 0x11, then idle.
   - `o_error` = 1 exactly 50 cycles after the strobe; no `o_wen`.
   - Status → 0 clears `o_error` the next cycle.
3. **First-byte wait and expiry race.**
   - Size 2, no bytes for 500 cycles: no `o_error`.
   - Send a byte exactly on the 50th cycle of the timer: no error, and the write completes.
4. **Abort and restart.** Size 4; after the write to addr 0, send one byte, then set status to 0.
   - Return to IDLE; no further writes.
   - Re-enter status 6 and send 2 bytes: the write goes to address 0.
5. **Empty load and back-to-back bytes.**
   - Size 0: `o_end` one cycle after status 6, with no writes.
   - Size 2 with `i_rx_valid` held high for 4 cycles: 2 writes, addresses 0 and 1.
6. **Asynchronous reset.** Assert `i_reset` low mid-frame, between clock edges.
   - All outputs go to 0 immediately.
   - After release, state is IDLE and address restarts at 0.
